// File: rtl/gpr_pkg.sv
// Shared widths, address/data types and fetch FSM encoding for the GPR
// operand-fetch slice.
package gpr_pkg;

  localparam int unsigned DATA_W   = 10;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 10;

  typedef logic [DATA_W-1:0] gpr_data_t;
  typedef logic [ADDR_W-1:0] gpr_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    HOLD
  } fetch_state_t;

  // True when the address names no implemented register
  function automatic logic addr_oob(gpr_addr_t a);
    return (int'(a) >= int'(NUM_REGS));
  endfunction

endpackage

// File: rtl/gpr_operand_fetch_if.sv
// GPR register-file port bundle: three read ports and one write port.
// master = initiator (operand fetch), slave = register file.
interface gpr_operand_fetch_if;
  import gpr_pkg::*;

  logic      read1, read2, read3;
  gpr_addr_t outaddr1, outaddr2, outaddr3;
  gpr_data_t outdata1, outdata2, outdata3;
  logic      write;
  gpr_addr_t inaddr;
  gpr_data_t indata;

  modport master (
    output read1, read2, read3,
    output outaddr1, outaddr2, outaddr3,
    input  outdata1, outdata2, outdata3,
    output write, inaddr, indata
  );

  modport slave (
    input  read1, read2, read3,
    input  outaddr1, outaddr2, outaddr3,
    output outdata1, outdata2, outdata3,
    input  write, inaddr, indata
  );

endinterface

// File: rtl/gpr_wb_stage.sv
// Writeback register slice: one accepted writeback becomes a single-cycle
// write pulse on the next cycle, or a wb_drop pulse if out of range.
module gpr_wb_stage
  import gpr_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_accept_i,
  input  gpr_addr_t wb_addr_i,
  input  gpr_data_t wb_data_i,
  output logic      write_o,
  output gpr_addr_t inaddr_o,
  output gpr_data_t indata_o,
  output logic      wb_drop_o
);

  logic      write_q, write_d;
  gpr_addr_t inaddr_q, inaddr_d;
  gpr_data_t indata_q, indata_d;
  logic      drop_q, drop_d;

  // Next pulse: idle port reads as all-zero, so fields clear when nothing accepted
  always_comb begin
    write_d  = 1'b0;
    inaddr_d = '0;
    indata_d = '0;
    drop_d   = 1'b0;
    if (wb_accept_i) begin
      if (addr_oob(wb_addr_i)) begin
        drop_d = 1'b1;
      end else begin
        write_d  = 1'b1;
        inaddr_d = wb_addr_i;
        indata_d = wb_data_i;
      end
    end
  end

  // Pulse registers; reset discards an in-flight writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      inaddr_q <= '0;
      indata_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      write_q  <= write_d;
      inaddr_q <= inaddr_d;
      indata_q <= indata_d;
      drop_q   <= drop_d;
    end
  end

  assign write_o   = write_q;
  assign inaddr_o  = inaddr_q;
  assign indata_o  = indata_q;
  assign wb_drop_o = drop_q;

endmodule

// File: rtl/gpr_operand_fetch.sv
// Operand fetch initiator for the GPR file: reads up to three source
// registers, returns them over op_valid/op_ready, and serialises writebacks.
// Optional macro GPR_BYPASS_EN: write pulses seen between the read and the
// capture forward their data into matching operands (latest wins).
module gpr_operand_fetch
  import gpr_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_valid,
  output logic      req_ready,
  input  logic [2:0] req_use,
  input  gpr_addr_t req_src1,
  input  gpr_addr_t req_src2,
  input  gpr_addr_t req_src3,
  output logic      op_valid,
  input  logic      op_ready,
  output gpr_data_t op1,
  output gpr_data_t op2,
  output gpr_data_t op3,
  output logic      op_err,
  input  logic      wb_valid,
  output logic      wb_ready,
  input  gpr_addr_t wb_addr,
  input  gpr_data_t wb_data,
  output logic      wb_drop,
  gpr_operand_fetch_if.master gpr
);

  fetch_state_t state_q, state_d;
  logic [2:0]   use_q, use_d;
  gpr_addr_t    src_q [3];
  gpr_addr_t    src_d [3];
  logic [1:0]   cnt_q, cnt_d;
  gpr_data_t    op_q  [3];
  gpr_data_t    op_d  [3];
  logic         err_q, err_d;

  logic [2:0]   rd_en;
  logic         req_acc;
  logic         capture;
  gpr_data_t    rdata    [3];
  gpr_data_t    cap_data [3];

  logic         wr_en;
  gpr_addr_t    wr_addr;
  gpr_data_t    wr_data;

  assign req_acc = req_valid && req_ready;
  assign capture = (state_q == WAIT) && (cnt_q == 2'd0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = HOLD;
      HOLD:    if (op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes and read-port enables
  always_comb begin
    req_ready = (state_q == IDLE);
    wb_ready  = (state_q == IDLE) || (state_q == HOLD);
    op_valid  = (state_q == HOLD);
    rd_en     = (state_q == READ) ? use_q : 3'b000;
  end

  // Read data gathered into an array for the capture mux
  always_comb begin
    rdata[0] = gpr.outdata1;
    rdata[1] = gpr.outdata2;
    rdata[2] = gpr.outdata3;
  end

`ifdef GPR_BYPASS_EN
  logic [2:0] hit;
  logic [2:0] fwd_v_q, fwd_v_d;
  gpr_data_t  fwd_q [3];
  gpr_data_t  fwd_d [3];

  // Forwarding: a live write pulse beats a remembered one, which beats the read data
  always_comb begin
    fwd_v_d = fwd_v_q;
    fwd_d   = fwd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      hit[i] = ((state_q == READ) || (state_q == WAIT)) && wr_en &&
               use_q[i] && (wr_addr == src_q[i]);
      cap_data[i] = hit[i] ? wr_data : (fwd_v_q[i] ? fwd_q[i] : rdata[i]);
      if (req_acc) begin
        fwd_v_d[i] = 1'b0;
      end else if (hit[i]) begin
        fwd_v_d[i] = 1'b1;
        fwd_d[i]   = wr_data;
      end
    end
  end

  // Forwarding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_v_q <= '0;
      for (int unsigned i = 0; i < 3; i++) fwd_q[i] <= '0;
    end else begin
      fwd_v_q <= fwd_v_d;
      fwd_q   <= fwd_d;
    end
  end
`else
  // Operands come straight from the register file, possibly stale
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) cap_data[i] = rdata[i];
  end
`endif

  // Datapath next-state: request latch, latency counter, operand capture
  always_comb begin
    use_d = use_q;
    src_d = src_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    err_d = err_q;
    if (req_acc) begin
      use_d    = req_use;
      src_d[0] = req_src1;
      src_d[1] = req_src2;
      src_d[2] = req_src3;
    end
    if (state_q == READ) cnt_d = 2'(RD_LAT - 1);
    if (state_q == WAIT && cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    if (capture) begin
      err_d = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        op_d[i] = use_q[i] ? cap_data[i] : '0;
        if (use_q[i] && addr_oob(src_q[i])) err_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      use_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        src_q[i] <= '0;
        op_q[i]  <= '0;
      end
    end else begin
      use_q <= use_d;
      src_q <= src_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      err_q <= err_d;
    end
  end

  gpr_wb_stage u_wb (
    .clk         (clk),
    .rst         (rst),
    .wb_accept_i (wb_valid && wb_ready),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .write_o     (wr_en),
    .inaddr_o    (wr_addr),
    .indata_o    (wr_data),
    .wb_drop_o   (wb_drop)
  );

  assign gpr.read1    = rd_en[0];
  assign gpr.read2    = rd_en[1];
  assign gpr.read3    = rd_en[2];
  assign gpr.outaddr1 = rd_en[0] ? src_q[0] : '0;
  assign gpr.outaddr2 = rd_en[1] ? src_q[1] : '0;
  assign gpr.outaddr3 = rd_en[2] ? src_q[2] : '0;
  assign gpr.write    = wr_en;
  assign gpr.inaddr   = wr_addr;
  assign gpr.indata   = wr_data;

  assign op1    = op_q[0];
  assign op2    = op_q[1];
  assign op3    = op_q[2];
  assign op_err = err_q;

endmodule
